// File: rtl/doorbell_mq.sv
// doorbell_mq
// Multi-queue NVMe doorbell writer. Each SQ tail / CQ head source owns a
// pending latch that coalesces repeated requests. A round-robin arbiter picks
// one pending source at a time and issues a one-dword memory write to the
// controller doorbell region over the PCIe RQ AXI-Stream interface.
//
// Ports:
//   user_clk, user_reset  clock and synchronous active-high reset
//   user_lnk_up           link up; low acts exactly like user_reset
//   sq_req / sq_tail      per-queue SQ tail write request and tail values
//   cq_req / cq_head      per-queue CQ head write request and head values
//   sq_done / cq_done     one-cycle pulse when a source's doorbell write completes
//   s_axis_rq_*           RQ AXI-Stream master (tready bit 0 is the handshake)
//   db_state              current FSM state, for debug
module doorbell_mq #(
  parameter int          NUM_QUEUES          = 4,
  parameter int          C_DATA_WIDTH        = 128,
  parameter int          AXI4_RQ_TUSER_WIDTH = 62,
  parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter logic [63:0] BAR0_ADDR           = 64'h0,
  parameter logic [63:0] DB_BASE_OFFSET      = 64'h1000,
  parameter int          DSTRD               = 0
) (
  input  logic                           user_clk,
  input  logic                           user_reset,
  input  logic                           user_lnk_up,
  input  logic [NUM_QUEUES-1:0]          sq_req,
  input  logic [16*NUM_QUEUES-1:0]       sq_tail,
  input  logic [NUM_QUEUES-1:0]          cq_req,
  input  logic [16*NUM_QUEUES-1:0]       cq_head,
  output logic [NUM_QUEUES-1:0]          sq_done,
  output logic [NUM_QUEUES-1:0]          cq_done,
  output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
  output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
  output logic                           s_axis_rq_tlast,
  output logic                           s_axis_rq_tvalid,
  input  logic [3:0]                     s_axis_rq_tready,
  output logic [3:0]                     db_state
);

  localparam int          NSRC     = 2 * NUM_QUEUES;
  localparam int          SRC_W    = $clog2(NSRC);
  localparam bit          WIDE     = (C_DATA_WIDTH == 256);
  localparam logic [63:0] DB_BASE  = BAR0_ADDR + DB_BASE_OFFSET;
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NSRC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              rst_s;
  logic              tready_s;
  logic              unused_tready_s;

  logic [NSRC-1:0]   req_s;
  logic [15:0]       new_val_s [NSRC];
  logic [NSRC-1:0]   pend_r;
  logic [15:0]       val_r [NSRC];

  logic [SRC_W-1:0]  rr_ptr_r, rr_nxt_s;
  logic [SRC_W-1:0]  cur_src_r;
  logic [15:0]       cur_val_r;
  logic              any_pend_s;
  logic [SRC_W-1:0]  sel_src_s;
  logic              grant_s;

  logic              emit_hdr_s, emit_data_s;
  logic [NSRC-1:0]   done_nxt_s, done_r;

  logic [SRC_W-1:0]  beat_src_s;
  logic [15:0]       beat_val_s;
  logic [63:0]       addr_s;
  logic [127:0]      desc_s;

  logic [C_DATA_WIDTH-1:0]        tdata_nxt_s;
  logic [KEEP_WIDTH-1:0]          tkeep_nxt_s;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] tuser_nxt_s;
  logic                           tlast_nxt_s;
  logic                           tvalid_nxt_s;

  assign rst_s           = user_reset | ~user_lnk_up;
  assign tready_s        = s_axis_rq_tready[0];
  assign unused_tready_s = ^s_axis_rq_tready[3:1];
  assign db_state        = {2'b00, state_r};

  // Flatten the SQ/CQ request buses into source order s = 2q + c.
  always_comb begin
    req_s     = '0;
    new_val_s = '{default: 16'h0000};
    for (int q = 0; q < NUM_QUEUES; q++) begin
      req_s[2*q]       = sq_req[q];
      req_s[2*q+1]     = cq_req[q];
      new_val_s[2*q]   = sq_tail[16*q +: 16];
      new_val_s[2*q+1] = cq_head[16*q +: 16];
    end
  end

  // Split the per-source done pulses back onto the SQ/CQ buses.
  always_comb begin
    sq_done = '0;
    cq_done = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      sq_done[q] = done_r[2*q];
      cq_done[q] = done_r[2*q+1];
    end
  end

  // Pending latches: a new request always wins over the grant clear, so a
  // request landing in the grant cycle stays pending with its fresh value.
  always_ff @(posedge user_clk) begin
    if (rst_s) begin
      pend_r <= '0;
      val_r  <= '{default: 16'h0000};
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (req_s[s]) begin
          pend_r[s] <= 1'b1;
          val_r[s]  <= new_val_s[s];
        end else if (grant_s && (sel_src_s == SRC_W'(s))) begin
          pend_r[s] <= 1'b0;
        end
      end
    end
  end

  // Round-robin search: first pending source at or after rr_ptr, wrapping.
  always_comb begin
    logic [SRC_W:0] sum_v;
    logic [SRC_W:0] idx_v;
    logic           hit_v;
    any_pend_s = 1'b0;
    sel_src_s  = '0;
    sum_v      = '0;
    idx_v      = '0;
    hit_v      = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      sum_v      = {1'b0, rr_ptr_r} + (SRC_W+1)'(i);
      idx_v      = (sum_v >= (SRC_W+1)'(NSRC)) ? (sum_v - (SRC_W+1)'(NSRC)) : sum_v;
      hit_v      = pend_r[idx_v[SRC_W-1:0]] & ~any_pend_s;
      sel_src_s  = hit_v ? idx_v[SRC_W-1:0] : sel_src_s;
      any_pend_s = any_pend_s | hit_v;
    end
  end

  // FSM next state, grant, done pulse and which beat to present next cycle.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    emit_hdr_s  = 1'b0;
    emit_data_s = 1'b0;
    done_nxt_s  = '0;
    rr_nxt_s    = rr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (any_pend_s) begin
          state_nxt_s = ST_HDR;
          grant_s     = 1'b1;
          emit_hdr_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (tready_s) begin
          if (WIDE) begin
            state_nxt_s           = ST_DONE;
            done_nxt_s[cur_src_r] = 1'b1;
          end else begin
            state_nxt_s = ST_DATA;
            emit_data_s = 1'b1;
          end
        end else begin
          emit_hdr_s = 1'b1;
        end
      end
      ST_DATA: begin
        if (tready_s) begin
          state_nxt_s           = ST_DONE;
          done_nxt_s[cur_src_r] = 1'b1;
        end else begin
          emit_data_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        rr_nxt_s    = (cur_src_r == LAST_SRC) ? '0 : (cur_src_r + SRC_W'(1));
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Beat contents. In IDLE the source being granted is not latched yet, so
  // the header is built from the arbiter's choice directly.
  always_comb begin
    beat_src_s = (state_r == ST_IDLE) ? sel_src_s : cur_src_r;
    beat_val_s = (state_r == ST_IDLE) ? val_r[sel_src_s] : cur_val_r;
    addr_s     = DB_BASE + (64'(beat_src_s) << (2 + DSTRD));
    // {ecrc, attr, tc, rid_en, cpl_id, tag, req_id, poison, type, dwords, addr, at}
    desc_s     = {1'b0, 3'b000, 3'b000, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b0,
                  4'b0001, 11'd1, addr_s[63:2], 2'b00};
    tdata_nxt_s  = '0;
    tkeep_nxt_s  = '0;
    tuser_nxt_s  = '0;
    tlast_nxt_s  = 1'b0;
    tvalid_nxt_s = 1'b0;
    if (emit_hdr_s) begin
      tvalid_nxt_s = 1'b1;
      tuser_nxt_s  = AXI4_RQ_TUSER_WIDTH'(8'h0F);
      if (WIDE) begin
        tdata_nxt_s = C_DATA_WIDTH'({96'h0, 16'h0000, beat_val_s, desc_s});
        tkeep_nxt_s = KEEP_WIDTH'(8'h1F);
        tlast_nxt_s = 1'b1;
      end else begin
        tdata_nxt_s = C_DATA_WIDTH'(desc_s);
        tkeep_nxt_s = KEEP_WIDTH'(8'h0F);
        tlast_nxt_s = 1'b0;
      end
    end else if (emit_data_s) begin
      tvalid_nxt_s = 1'b1;
      tdata_nxt_s  = C_DATA_WIDTH'({16'h0000, beat_val_s});
      tkeep_nxt_s  = KEEP_WIDTH'(8'h01);
      tlast_nxt_s  = 1'b1;
      tuser_nxt_s  = '0;
    end else begin
      tvalid_nxt_s = 1'b0;
    end
  end

  // State, arbitration context and registered outputs share one edge.
  always_ff @(posedge user_clk) begin
    if (rst_s) begin
      state_r          <= ST_IDLE;
      rr_ptr_r         <= '0;
      cur_src_r        <= '0;
      cur_val_r        <= 16'h0000;
      done_r           <= '0;
      s_axis_rq_tdata  <= '0;
      s_axis_rq_tkeep  <= '0;
      s_axis_rq_tuser  <= '0;
      s_axis_rq_tlast  <= 1'b0;
      s_axis_rq_tvalid <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_nxt_s;
      if (grant_s) begin
        cur_src_r <= sel_src_s;
        cur_val_r <= val_r[sel_src_s];
      end
      done_r           <= done_nxt_s;
      s_axis_rq_tdata  <= tdata_nxt_s;
      s_axis_rq_tkeep  <= tkeep_nxt_s;
      s_axis_rq_tuser  <= tuser_nxt_s;
      s_axis_rq_tlast  <= tlast_nxt_s;
      s_axis_rq_tvalid <= tvalid_nxt_s;
    end
  end

endmodule
